ms_uart_rx: RTL

MS_UART_RX -- requirements
Module: ms_uart_rx

---
 rtl/ms_uart_pkg.sv | 33 +++
 rtl/ms_uart_rx_if.sv | 27 ++
 rtl/ms_uart_baudgen.sv | 28 ++
 rtl/ms_uart_rx.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ms_uart_pkg.sv
// UART receiver shared types and constants.
// Oversampling geometry and FSM state encoding.
package ms_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int OVS       = 16;
  localparam int SMP0      = 7;
  localparam int SMP1      = 8;
  localparam int SMP2      = 9;
  localparam int DATA_BITS = 8;

  localparam logic [3:0] TICK_LAST = 4'(OVS - 1);
  localparam logic [3:0] TICK_S0   = 4'(SMP0);
  localparam logic [3:0] TICK_S1   = 4'(SMP1);
  localparam logic [3:0] TICK_S2   = 4'(SMP2);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/ms_uart_rx_if.sv
// Receiver output bundle: data, strobes and status.
// master drives it, slave (RX FIFO side) observes it.
interface ms_uart_rx_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input frame_err,
    input parity_err,
    input busy
  );

endinterface

// File: rtl/ms_uart_baudgen.sv
// Baud tick divider: one tick every prescale+1 cycles.
// Shared between receiver and transmitter.
module ms_uart_baudgen (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] prescale,
  output logic        tick
);

  logic [15:0] r_cnt;
  logic        w_wrap;

  // >= lets a lowered prescale take effect without a long wrap
  assign w_wrap = (r_cnt >= prescale);
  assign tick   = en & (r_cnt == prescale);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/ms_uart_rx.sv
// UART receiver: 16x oversampling, 2-of-3 vote, parity.
// Emits registered one-cycle strobes per frame.
module ms_uart_rx
  import ms_uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] prescale,
  input  logic        parity_en,
  input  logic        parity_odd,
  input  logic        RX,
  ms_uart_rx_if.master rx_if
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx;
  logic                   w_tick;

  state_t     r_state, w_state_n;
  logic [3:0] r_tick,  w_tick_n;
  logic [2:0] r_bit,   w_bit_n;
  logic [7:0] r_shift, w_shift_n;
  logic       r_s7,    w_s7_n;
  logic       r_s8,    w_s8_n;
  logic       r_pen,   w_pen_n;
  logic       r_podd,  w_podd_n;
  logic       r_pbad,  w_pbad_n;
  logic       r_armed, w_armed_n;
  logic [7:0] r_data,  w_data_n;
  logic       r_valid, w_valid_n;
  logic       r_ferr,  w_ferr_n;
  logic       r_perr,  w_perr_n;
  logic       w_maj;

  ms_uart_baudgen u_baud (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .prescale (prescale),
    .tick     (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], RX};
    end
  end

  assign w_rx  = r_sync[SYNC_STAGES-1];
  assign w_maj = maj3(r_s7, r_s8, w_rx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_s7    <= 1'b1;
      r_s8    <= 1'b1;
      r_pen   <= 1'b0;
      r_podd  <= 1'b0;
      r_pbad  <= 1'b0;
      r_armed <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_tick  <= w_tick_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_s7    <= w_s7_n;
      r_s8    <= w_s8_n;
      r_pen   <= w_pen_n;
      r_podd  <= w_podd_n;
      r_pbad  <= w_pbad_n;
      r_armed <= w_armed_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_ferr  <= w_ferr_n;
      r_perr  <= w_perr_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_tick_n  = r_tick;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_s7_n    = r_s7;
    w_s8_n    = r_s8;
    w_pen_n   = r_pen;
    w_podd_n  = r_podd;
    w_pbad_n  = r_pbad;
    w_armed_n = r_armed;
    w_data_n  = r_data;
    w_valid_n = 1'b0;
    w_ferr_n  = 1'b0;
    w_perr_n  = 1'b0;

    if (!en) begin
      w_state_n = IDLE;
      w_tick_n  = '0;
      w_bit_n   = '0;
      w_armed_n = 1'b0;
    end else if (w_tick) begin
      if (r_state != IDLE) begin
        w_tick_n = r_tick + 4'd1;
        if (r_tick == TICK_S0) w_s7_n = w_rx;
        if (r_tick == TICK_S1) w_s8_n = w_rx;
      end
      unique case (r_state)
        IDLE: begin
          w_tick_n = '0;
          // a break must see the line high before re-arming
          if (!w_rx && r_armed) begin
            w_state_n = START;
            w_armed_n = 1'b0;
          end else if (w_rx) begin
            w_armed_n = 1'b1;
          end
        end
        START: begin
          if (r_tick == TICK_S2 && w_maj) begin
            w_state_n = IDLE;
            w_tick_n  = '0;
          end else if (r_tick == TICK_LAST) begin
            w_state_n = DATA;
            w_bit_n   = '0;
            w_pen_n   = parity_en;
            w_podd_n  = parity_odd;
            w_pbad_n  = 1'b0;
          end
        end
        DATA: begin
          if (r_tick == TICK_S2) w_shift_n = {w_maj, r_shift[7:1]};
          if (r_tick == TICK_LAST) begin
            if (r_bit == BIT_LAST) begin
              w_state_n = r_pen ? PARITY : STOP;
            end else begin
              w_bit_n = r_bit + 3'd1;
            end
          end
        end
        PARITY: begin
          if (r_tick == TICK_S2) w_pbad_n = w_maj ^ (^r_shift) ^ r_podd;
          if (r_tick == TICK_LAST) w_state_n = STOP;
        end
        STOP: begin
          if (r_tick == TICK_S2) begin
            w_state_n = IDLE;
            w_tick_n  = '0;
            if (!w_maj) begin
              w_ferr_n = 1'b1;
            end else if (r_pbad) begin
              w_perr_n = 1'b1;
            end else begin
              w_valid_n = 1'b1;
              w_data_n  = r_shift;
            end
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  assign rx_if.rx_data    = r_data;
  assign rx_if.rx_valid   = r_valid;
  assign rx_if.frame_err  = r_ferr;
  assign rx_if.parity_err = r_perr;
  assign rx_if.busy       = (r_state != IDLE);

endmodule
